hash_pts_streamer: RTL and testbench
====================================

Name: hash_pts_streamer

Overview:
- Parallel-to-serial unloader; the transmit-side counterpart of the 8-bit-per-shift hash capture register.
- Captures a wide hash/password buffer in one cycle and streams it out one byte per accepted valid/ready handshake.
- Sits between the cracker result buffer and the byte-wide host/output interface.
- Byte order is MSB-first: feeding its output into the capture register rebuilds the original word.

Parameters:
- NUM_BYTES, 1024, number of bytes in the parallel word (must be >= 2).
- BYTE_W, 8, width of one serial beat.

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- load  input  1  request to capture parallel_in; accepted only in IDLE
- parallel_in  input  NUM_BYTES*BYTE_W  word to stream
- serial_out  output  BYTE_W  current byte
- out_valid  output  1  serial_out holds a valid byte
- out_ready  input  1  downstream accepts serial_out this cycle
- busy  output  1  high from load acceptance until the final byte is accepted
- done  output  1  one-cycle pulse on the cycle after the final handshake
- byte_cnt  output  $clog2(NUM_BYTES+1)  bytes accepted so far in the current transfer

Behaviour:
- Clock and reset: one clock, clk. n_rst is asynchronous, active-low.
- Reset values: state=IDLE, shift register=0, serial_out=0, out_valid=0, busy=0, done=0, byte_cnt=0. Reset asserted mid-transfer aborts immediately; no done pulse is issued.
- FSM states: IDLE, SEND, plus CSUM only when CHECKSUM_EN is defined.
- IDLE:
  - When load=1: capture parallel_in into the shift register, byte_cnt<=0, go to SEND.
  - out_valid rises on the next cycle, so first-byte latency is 1 cycle after load.
- SEND:
  - out_valid=1, busy=1.
  - serial_out = shift register bits [NUM_BYTES*BYTE_W-1 -: BYTE_W].
- Handshake (out_valid && out_ready):
  - Shift register shifts left by BYTE_W with zero fill; byte_cnt increments.
  - While out_ready=0, serial_out and out_valid must hold stable. No byte is dropped or repeated.
- Last byte: the handshake at byte_cnt==NUM_BYTES-1 sets byte_cnt to NUM_BYTES and moves to IDLE (or CSUM).
  - done pulses for 1 cycle in the following cycle.
  - busy drops in that same following cycle.
  - byte_cnt holds NUM_BYTES until the next load.
- Throughput: with out_ready held high, one byte per cycle; a full transfer takes NUM_BYTES cycles after load.
- Simultaneous events:
  - load while busy (including the final-handshake cycle) is ignored.
  - load in the done cycle is accepted, allowing back-to-back transfers with one idle cycle between them.
- parallel_in is sampled only at load acceptance; later changes have no effect on the transfer.

Optional Feature:
- Macro: HASH_PTS_CHECKSUM_EN.
- Defined:
  - An 8-bit running checksum accumulates every sent byte, sum mod 256, cleared on load.
  - After the last data byte, the FSM enters CSUM and presents the checksum as one extra beat under the same handshake rules.
  - done and busy-fall occur after the checksum beat is accepted, so a transfer is NUM_BYTES+1 beats.
  - byte_cnt counts data bytes only.
- Undefined: no CSUM state, no accumulator; exactly NUM_BYTES beats.

Decomposition:
- Package hash_pkg holds:
  - BYTE_W and the default NUM_BYTES (1024);
  - the state enum typedef (IDLE, SEND, CSUM);
  - a byte_t typedef (logic [BYTE_W-1:0]).
- One natural sub-module: hash_byte_counter.
  - Parameterised up-counter with clear, enable and a terminal flag at NUM_BYTES-1.
  - Reused by the receive-side control.
- Shift register, FSM and checksum stay in the top module.

Test Plan (NUM_BYTES=4 unless noted):
- Basic transfer: load with 0xDEADBEEF, out_ready=1 → bytes DE, AD, BE, EF on 4 consecutive cycles starting 1 cycle after load; done pulses 1 cycle after the EF handshake; byte_cnt=4.
- Backpressure: same word, out_ready low for 3 cycles while AD is presented → serial_out stays AD with out_valid=1; the full sequence completes unchanged.
- Busy and data stability: load with 0x11223344, then load=1 with parallel_in=0xFFFFFFFF during the transfer → ignored; output is 11, 22, 33, 44. A second load in the done cycle is accepted and streams the new word.
- Mid-transfer reset: n_rst pulsed low after 2 bytes → all outputs 0 immediately, no done pulse; a subsequent load restarts from byte 0.
- Checksum (HASH_PTS_CHECKSUM_EN defined): word 0x01020304 → beats 01, 02, 03, 04, 0A; done after the 0A handshake.
- Loopback at default NUM_BYTES=1024: random 8192-bit word streamed into the capture register with shift_enable = out_valid && out_ready → captured word equals the source word.

Source files
------------

// File: rtl/hash_pkg.sv
// hash_pkg: shared types and constants for the hash parallel-to-serial streamer
// and its receive-side counterpart.
package hash_pkg;

    // Width of one serial beat and the default parallel word size in bytes.
    localparam int BYTE_W        = 8;
    localparam int NUM_BYTES_DEF = 1024;

    // One serial beat; the running checksum is also one of these.
    typedef logic [BYTE_W-1:0] byte_t;

    // Streamer control states; CSUM is only reachable in checksum builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CSUM = 2'd2
    } state_t;

endpackage

// File: rtl/hash_pts_streamer_if.sv
// hash_pts_streamer_if: byte-wide valid/ready stream between the streamer
// (master) and the downstream host/output interface (slave).
interface hash_pts_streamer_if #(
    parameter int BYTE_W = 8
) ();

    logic [BYTE_W-1:0] serial_out;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output serial_out,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  serial_out,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/hash_byte_counter.sv
// hash_byte_counter: up-counter with synchronous clear and enable, flagging the
// last byte (count == NUM_BYTES-1). Shared by transmit and receive control.
module hash_byte_counter #(
    parameter  int NUM_BYTES = 1024,
    localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             term_o
);

    localparam logic [CNT_W-1:0] TERM_VAL = CNT_W'(NUM_BYTES - 1);

    logic [CNT_W-1:0] count_q;

    // Count accepted bytes; clear has priority over enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            count_q <= {CNT_W{1'b0}};
        end else if (en_i) begin
            count_q <= count_q + CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign count_o = count_q;
    assign term_o  = (count_q == TERM_VAL);

endmodule

// File: rtl/hash_pts_streamer.sv
// hash_pts_streamer: captures a NUM_BYTES*BYTE_W word in one cycle and streams
// it MSB-first, one byte per accepted valid/ready handshake.
// Optional feature macro: HASH_PTS_CHECKSUM_EN -- appends one extra beat
// carrying the 8-bit sum (mod 256) of all data bytes sent.
module hash_pts_streamer #(
    parameter  int NUM_BYTES = hash_pkg::NUM_BYTES_DEF,
    parameter  int BYTE_W    = hash_pkg::BYTE_W,
    localparam int CNT_W     = $clog2(NUM_BYTES + 1),
    localparam int WORD_W    = NUM_BYTES * BYTE_W
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic [WORD_W-1:0]    parallel_in,
    hash_pts_streamer_if.master  tx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     byte_cnt
);

    import hash_pkg::*;

    // The head of the shift register is the byte on the wire, so serial_out
    // is a direct register slice. In checksum builds the checksum is loaded
    // into the head after the last data byte and leaves by the same path.
    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] shreg_shift_s;
    logic              out_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              hs_s;
    logic              load_acc_s;
    logic              cnt_en_s;
    logic              term_s;
    logic [CNT_W-1:0]  cnt_s;

`ifdef HASH_PTS_CHECKSUM_EN
    byte_t             csum_q;
    byte_t             csum_nxt_s;
`endif

    assign hs_s          = out_valid_q && tx.out_ready;
    assign load_acc_s    = (state_q == IDLE) && load;
    assign cnt_en_s      = hs_s && (state_q == SEND);
    assign shreg_shift_s = {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};

`ifdef HASH_PTS_CHECKSUM_EN
    assign csum_nxt_s    = csum_q + byte_t'(shreg_q[WORD_W-1 -: BYTE_W]);
`endif

    hash_byte_counter #(
        .NUM_BYTES (NUM_BYTES)
    ) u_cnt (
        .clk     (clk),
        .n_rst   (n_rst),
        .clr_i   (load_acc_s),
        .en_i    (cnt_en_s),
        .count_o (cnt_s),
        .term_o  (term_s)
    );

    // Control FSM with registered valid/busy/done and the data shift register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            shreg_q     <= {WORD_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef HASH_PTS_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (load) begin
                        shreg_q     <= parallel_in;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= SEND;
`ifdef HASH_PTS_CHECKSUM_EN
                        csum_q      <= 8'h00;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end

                SEND: begin
                    if (hs_s) begin
`ifdef HASH_PTS_CHECKSUM_EN
                        csum_q <= csum_nxt_s;
                        if (term_s) begin
                            // Checksum becomes the next beat on the wire.
                            shreg_q <= {BYTE_W'(csum_nxt_s), {(WORD_W-BYTE_W){1'b0}}};
                            state_q <= CSUM;
                        end else begin
                            shreg_q <= shreg_shift_s;
                        end
`else
                        shreg_q <= shreg_shift_s;
                        if (term_s) begin
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= SEND;
                        end
`endif
                    end else begin
                        state_q <= SEND;
                    end
                end

`ifdef HASH_PTS_CHECKSUM_EN
                CSUM: begin
                    if (hs_s) begin
                        shreg_q     <= shreg_shift_s;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= CSUM;
                    end
                end
`endif

                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    shreg_q     <= {WORD_W{1'b0}};
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign tx.serial_out = shreg_q[WORD_W-1 -: BYTE_W];
    assign tx.out_valid  = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign byte_cnt      = cnt_s;

endmodule

// File: tb/tb_hash_pts_streamer.sv
// Directed bench for hash_pts_streamer: a 4-byte instance for the directed
// scenarios and a 1024-byte instance looped into a capture register.
module tb_hash_pts_streamer;

    localparam int NB  = 4;
    localparam int BW  = 8;
    localparam int CW  = $clog2(NB + 1);
    localparam int BIG = 1024;
    localparam int BCW = $clog2(BIG + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          n_rst;
    logic          load;
    logic [31:0]   pin;
    logic          busy;
    logic          done;
    logic [CW-1:0] cnt;

    logic            bload;
    logic [8191:0]   bpin;
    logic [8191:0]   src;
    logic [8191:0]   cap;
    logic            bbusy;
    logic            bdone;
    logic [BCW-1:0]  bcnt;

    int passed = 0;
    int total  = 0;

    hash_pts_streamer_if #(.BYTE_W(BW)) sif ();
    hash_pts_streamer_if #(.BYTE_W(BW)) bif ();

    hash_pts_streamer #(.NUM_BYTES(NB), .BYTE_W(BW)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .load        (load),
        .parallel_in (pin),
        .tx          (sif.master),
        .busy        (busy),
        .done        (done),
        .byte_cnt    (cnt)
    );

    hash_pts_streamer #(.NUM_BYTES(BIG), .BYTE_W(BW)) dut_big (
        .clk         (clk),
        .n_rst       (n_rst),
        .load        (bload),
        .parallel_in (bpin),
        .tx          (bif.master),
        .busy        (bbusy),
        .done        (bdone),
        .byte_cnt    (bcnt)
    );

    // Receive-side capture register: shifts in one byte per data handshake.
    always @(posedge clk) begin
        if (bif.out_valid && bif.out_ready && (bcnt != BCW'(BIG)))
            cap <= {cap[8183:0], bif.serial_out};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [7:0] b, input int c);
        check({tag, " valid"}, {31'd0, sif.out_valid}, 32'd1);
        check({tag, " byte"},  {24'd0, sif.serial_out}, {24'd0, b});
        check({tag, " cnt"},   {29'd0, cnt}, c);
        check({tag, " busy"},  {31'd0, busy}, 32'd1);
    endtask

    task automatic csum_beat(input string tag, input logic [7:0] cs);
        check({tag, " cs valid"}, {31'd0, sif.out_valid}, 32'd1);
        check({tag, " cs byte"},  {24'd0, sif.serial_out}, {24'd0, cs});
        check({tag, " cs cnt"},   {29'd0, cnt}, NB);
        check({tag, " cs busy"},  {31'd0, busy}, 32'd1);
    endtask

    task automatic tail(input string tag);
        check({tag, " done"},  {31'd0, done}, 32'd1);
        check({tag, " busy"},  {31'd0, busy}, 32'd0);
        check({tag, " valid"}, {31'd0, sif.out_valid}, 32'd0);
        check({tag, " cnt"},   {29'd0, cnt}, NB);
    endtask

    initial begin
        int k;
        n_rst = 1'b0; load = 1'b0; pin = 32'd0; sif.out_ready = 1'b0;
        bload = 1'b0; bpin = '0; bif.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst valid", {31'd0, sif.out_valid}, 32'd0);
        check("rst byte",  {24'd0, sif.serial_out}, 32'd0);
        check("rst busy",  {31'd0, busy}, 32'd0);
        check("rst done",  {31'd0, done}, 32'd0);
        check("rst cnt",   {29'd0, cnt}, 32'd0);
        step();
        n_rst = 1'b1;
        step();
        check("idle valid", {31'd0, sif.out_valid}, 32'd0);

        // Basic transfer
        pin = 32'hDEADBEEF; load = 1'b1; sif.out_ready = 1'b1;
        step(); load = 1'b0;
        beat("t1 b0", 8'hDE, 0); step();
        beat("t1 b1", 8'hAD, 1); step();
        beat("t1 b2", 8'hBE, 2); step();
        beat("t1 b3", 8'hEF, 3); step();
`ifdef HASH_PTS_CHECKSUM_EN
        csum_beat("t1", 8'h38); step();
`endif
        tail("t1"); step();
        check("t1 done low", {31'd0, done}, 32'd0);
        check("t1 cnt hold", {29'd0, cnt}, NB);

        // Backpressure while AD is presented
        pin = 32'hDEADBEEF; load = 1'b1;
        step(); load = 1'b0;
        beat("t2 b0", 8'hDE, 0); step();
        beat("t2 b1", 8'hAD, 1);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            beat("t2 stall", 8'hAD, 1);
        end
        sif.out_ready = 1'b1;
        step();
        beat("t2 b2", 8'hBE, 2); step();
        beat("t2 b3", 8'hEF, 3); step();
`ifdef HASH_PTS_CHECKSUM_EN
        csum_beat("t2", 8'h38); step();
`endif
        tail("t2"); step();

        // Load while busy ignored; load in done cycle accepted
        pin = 32'h11223344; load = 1'b1;
        step();
        beat("t3 b0", 8'h11, 0);
        pin = 32'hFFFFFFFF;
        step(); beat("t3 b1", 8'h22, 1);
        step(); beat("t3 b2", 8'h33, 2);
        step(); beat("t3 b3", 8'h44, 3);
        step();
`ifdef HASH_PTS_CHECKSUM_EN
        csum_beat("t3", 8'hAA); step();
`endif
        tail("t3");
        pin = 32'hA1B2C3D4;
        step(); load = 1'b0;
        beat("t3 n0", 8'hA1, 0); step();
        beat("t3 n1", 8'hB2, 1); step();
        beat("t3 n2", 8'hC3, 2); step();
        beat("t3 n3", 8'hD4, 3); step();
`ifdef HASH_PTS_CHECKSUM_EN
        csum_beat("t3n", 8'hEA); step();
`endif
        tail("t3n"); step();

        // Mid-transfer reset after two bytes
        pin = 32'hDEADBEEF; load = 1'b1;
        step(); load = 1'b0;
        beat("t4 b0", 8'hDE, 0); step();
        beat("t4 b1", 8'hAD, 1); step();
        beat("t4 b2", 8'hBE, 2);
        #2; n_rst = 1'b0; #1;
        check("t4 rst valid", {31'd0, sif.out_valid}, 32'd0);
        check("t4 rst byte",  {24'd0, sif.serial_out}, 32'd0);
        check("t4 rst busy",  {31'd0, busy}, 32'd0);
        check("t4 rst cnt",   {29'd0, cnt}, 32'd0);
        step();
        check("t4 no done", {31'd0, done}, 32'd0);
        n_rst = 1'b1;
        step();
        check("t4 idle done", {31'd0, done}, 32'd0);
        check("t4 idle valid", {31'd0, sif.out_valid}, 32'd0);
        pin = 32'h01020304; load = 1'b1;
        step(); load = 1'b0;
        beat("t4 r0", 8'h01, 0); step();
        beat("t4 r1", 8'h02, 1); step();
        beat("t4 r2", 8'h03, 2); step();
        beat("t4 r3", 8'h04, 3); step();
`ifdef HASH_PTS_CHECKSUM_EN
        csum_beat("t4", 8'h0A); step();
`endif
        tail("t4"); step();

        // Loopback at 1024 bytes with random backpressure
        for (int i = 0; i < 256; i++) src[i*32 +: 32] = $urandom;
        bpin = src; bload = 1'b1; bif.out_ready = 1'b1;
        step(); bload = 1'b0;
        k = 0;
        while (!bdone && k < 5000) begin
            bif.out_ready = ($urandom_range(0, 3) != 0);
            step();
            k++;
        end
        check("lb done", {31'd0, bdone}, 32'd1);
        check("lb cnt",  {21'd0, bcnt}, BIG);
        total++;
        assert (cap === src) passed++;
        else $error("FAIL lb word: observed top %0h expected top %0h", cap[8191 -: 32], src[8191 -: 32]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
